sdram_avalon_arbiter: RTL and testbench

//  Shares the single Avalon-MM burst slave of the SDRAM controller between two Avalon-MM masters
//  (m0, e.g. CPU; m1, e.g. video/DMA). Round-robin, one whole burst transaction per grant.

---
 rtl/sdram_arb_pkg.sv | 26 ++
 rtl/rr_arb2.sv | 18 +
 rtl/sdram_avalon_arbiter.sv | 139 +++++++++++++
 tb/tb_sdram_avalon_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-master SDRAM Avalon burst arbiter.
package sdram_arb_pkg;

    localparam int ADDR_W_DEF  = 22;
    localparam int DATA_W_DEF  = 16;
    localparam int BURST_W_DEF = 9;

    localparam int unsigned BC_1   = 1;
    localparam int unsigned BC_2   = 2;
    localparam int unsigned BC_4   = 4;
    localparam int unsigned BC_8   = 8;
    localparam int unsigned BC_256 = 256;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        WBURST,
        WDONE,
        RDATA
    } arb_state_t;

    function automatic logic is_legal_bc(input int unsigned bc);
        return (bc == BC_1) || (bc == BC_2) || (bc == BC_4) || (bc == BC_8) || (bc == BC_256);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on a tie the master that did not win last time is chosen.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       grant_o,
    output logic       valid_o
);

    always_comb begin
        valid_o = |req_i;
        if (req_i == 2'b11) begin
            grant_o = ~last_grant_i;
        end else begin
            grant_o = req_i[1];
        end
    end

endmodule

// File: rtl/sdram_avalon_arbiter.sv
// Shares the SDRAM controller's Avalon-MM burst slave between two masters,
// one complete burst transaction per grant, round-robin between requesters.
module sdram_avalon_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int BURST_W = BURST_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               m0_read,
    input  logic               m0_write,
    input  logic [ADDR_W-1:0]  m0_address,
    input  logic [DATA_W-1:0]  m0_writedata,
    input  logic [BURST_W-1:0] m0_burstcount,
    input  logic [1:0]         m0_byteenable,
    output logic               m0_waitrequest,
    output logic               m0_readdatavalid,
    output logic [DATA_W-1:0]  m0_readdata,
    input  logic               m1_read,
    input  logic               m1_write,
    input  logic [ADDR_W-1:0]  m1_address,
    input  logic [DATA_W-1:0]  m1_writedata,
    input  logic [BURST_W-1:0] m1_burstcount,
    input  logic [1:0]         m1_byteenable,
    output logic               m1_waitrequest,
    output logic               m1_readdatavalid,
    output logic [DATA_W-1:0]  m1_readdata,
    output logic               s_read,
    output logic               s_write,
    output logic [ADDR_W-1:0]  s_address,
    output logic [DATA_W-1:0]  s_writedata,
    output logic [BURST_W-1:0] s_burstcount,
    output logic [1:0]         s_byteenable,
    input  logic               s_waitrequest,
    input  logic               s_readdatavalid,
    input  logic [DATA_W-1:0]  s_readdata,
    output arb_state_t         dbg_state_o
);

    // Handshake: a command or write beat transfers on a rising edge where
    // s_read/s_write is high and s_waitrequest is low; read beats transfer on
    // every edge with s_readdatavalid high while in RDATA.

    arb_state_t         state_q;
    logic               owner_q;
    logic               last_grant_q;
    logic [BURST_W-1:0] bc_q;
    logic [BURST_W:0]   beat_cnt_q;

    logic               pick_idx;
    logic               pick_valid;
    logic               own_read;
    logic               own_write;
    logic               in_cmd;
    logic               rd_beat;
    logic [BURST_W:0]   beat_inc;
    logic [BURST_W:0]   bc_ext;

    rr_arb2 u_rr (
        .req_i        ({m1_read | m1_write, m0_read | m0_write}),
        .last_grant_i (last_grant_q),
        .grant_o      (pick_idx),
        .valid_o      (pick_valid)
    );

    assign own_read  = owner_q ? m1_read  : m0_read;
    assign own_write = owner_q ? m1_write : m0_write;
    assign in_cmd    = (state_q == GRANT) || (state_q == WBURST);
    assign rd_beat   = (state_q == RDATA) && s_readdatavalid;
    assign beat_inc  = beat_cnt_q + (BURST_W+1)'(1);
    assign bc_ext    = {1'b0, bc_q};

    assign s_read       = (state_q == GRANT) && own_read;
    assign s_write      = in_cmd && own_write;
    assign s_address    = owner_q ? m1_address    : m0_address;
    assign s_writedata  = owner_q ? m1_writedata  : m0_writedata;
    assign s_burstcount = owner_q ? m1_burstcount : m0_burstcount;
    assign s_byteenable = owner_q ? m1_byteenable : m0_byteenable;

    assign m0_waitrequest   = (in_cmd && !owner_q) ? s_waitrequest : 1'b1;
    assign m1_waitrequest   = (in_cmd &&  owner_q) ? s_waitrequest : 1'b1;
    assign m0_readdatavalid = rd_beat && !owner_q;
    assign m1_readdatavalid = rd_beat &&  owner_q;
    assign m0_readdata      = m0_readdatavalid ? s_readdata : '0;
    assign m1_readdata      = m1_readdatavalid ? s_readdata : '0;

    assign dbg_state_o = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            bc_q         <= '0;
            beat_cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        owner_q      <= pick_idx;
                        last_grant_q <= pick_idx;
                        bc_q         <= pick_idx ? m1_burstcount : m0_burstcount;
                        beat_cnt_q   <= '0;
                        state_q      <= GRANT;
                    end
                end
                GRANT: begin
                    if (!s_waitrequest) begin
                        if (own_read) begin
                            beat_cnt_q <= '0;
                            state_q    <= RDATA;
                        end else if (own_write) begin
                            beat_cnt_q <= (BURST_W+1)'(1);
                            state_q    <= (bc_q == BURST_W'(1)) ? WDONE : WBURST;
                        end
                    end
                end
                WBURST: begin
                    if (own_write && !s_waitrequest) begin
                        beat_cnt_q <= beat_inc;
                        if (beat_inc == bc_ext) state_q <= WDONE;
                    end
                end
                // Dropping s_write for a cycle is what closes the burst at the controller.
                WDONE: state_q <= IDLE;
                RDATA: begin
                    if (s_readdatavalid) begin
                        beat_cnt_q <= beat_inc;
                        if (beat_inc == bc_ext) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_avalon_arbiter.sv
// Directed bench for sdram_avalon_arbiter: inputs change on the falling edge,
// outputs are checked 1 ns later.
module tb_sdram_avalon_arbiter;
    import sdram_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [21:0] m0_address, m1_address;
    logic [15:0] m0_writedata, m1_writedata;
    logic [8:0]  m0_burstcount, m1_burstcount;
    logic [1:0]  m0_byteenable, m1_byteenable;
    logic        m0_waitrequest, m0_readdatavalid, m1_waitrequest, m1_readdatavalid;
    logic [15:0] m0_readdata, m1_readdata;
    logic        s_read, s_write;
    logic [21:0] s_address;
    logic [15:0] s_writedata;
    logic [8:0]  s_burstcount;
    logic [1:0]  s_byteenable;
    logic        s_waitrequest, s_readdatavalid;
    logic [15:0] s_readdata;
    arb_state_t  dbg_state;

    int checks   = 0;
    int failures = 0;
    int rd_cmds  = 0;
    int wr_beats = 0;

    always #5 clk = ~clk;

    sdram_avalon_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
        .m0_writedata(m0_writedata), .m0_burstcount(m0_burstcount), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdatavalid(m0_readdatavalid), .m0_readdata(m0_readdata),
        .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
        .m1_writedata(m1_writedata), .m1_burstcount(m1_burstcount), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdatavalid(m1_readdatavalid), .m1_readdata(m1_readdata),
        .s_read(s_read), .s_write(s_write), .s_address(s_address), .s_writedata(s_writedata),
        .s_burstcount(s_burstcount), .s_byteenable(s_byteenable), .s_waitrequest(s_waitrequest),
        .s_readdatavalid(s_readdatavalid), .s_readdata(s_readdata), .dbg_state_o(dbg_state)
    );

    // Controller-side transfer counters.
    always @(posedge clk) begin
        if (s_read && !s_waitrequest) rd_cmds <= rd_cmds + 1;
        if (s_write && !s_waitrequest) wr_beats <= wr_beats + 1;
    end

    always @(posedge clk) begin
        if (!reset && (m0_read || m0_write) && !is_legal_bc(32'(m0_burstcount)))
            $error("illegal m0 burstcount %0d", m0_burstcount);
        if (!reset && (m1_read || m1_write) && !is_legal_bc(32'(m1_burstcount)))
            $error("illegal m1 burstcount %0d", m1_burstcount);
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_m(input int who, input logic rd, input logic wr, input logic [21:0] a,
                         input logic [15:0] d, input logic [8:0] bc);
        if (who == 0) begin
            m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_burstcount = bc;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_burstcount = bc;
        end
    endtask

    task automatic check_grant(input int who, input logic rd, input logic [21:0] a, input logic [8:0] bc);
        step(); settle();
        chk("grant_state", 32'(dbg_state), 32'(GRANT));
        chk("grant_s_read", 32'(s_read), 32'(rd));
        chk("grant_s_write", 32'(s_write), 32'(!rd));
        chk("grant_addr", 32'(s_address), 32'(a));
        chk("grant_bc", 32'(s_burstcount), 32'(bc));
        chk("grant_own_wait", 32'(who == 0 ? m0_waitrequest : m1_waitrequest), 32'(0));
        chk("grant_oth_wait", 32'(who == 0 ? m1_waitrequest : m0_waitrequest), 32'(1));
    endtask

    task automatic read_beats(input int who, input int bc, input logic [15:0] base, input bit keep);
        step();
        if (!keep) begin
            if (who == 0) m0_read = 1'b0; else m1_read = 1'b0;
        end
        settle();
        chk("rdata_state", 32'(dbg_state), 32'(RDATA));
        chk("rdata_s_read", 32'(s_read), 32'(0));
        for (int i = 0; i < bc; i++) begin
            if (i % 3 == 2) begin
                step(); s_readdatavalid = 1'b0; settle();
                chk("gap_rdv", 32'(who == 0 ? m0_readdatavalid : m1_readdatavalid), 32'(0));
            end
            step(); s_readdatavalid = 1'b1; s_readdata = base + 16'(i); settle();
            chk("own_rdv", 32'(who == 0 ? m0_readdatavalid : m1_readdatavalid), 32'(1));
            chk("oth_rdv", 32'(who == 0 ? m1_readdatavalid : m0_readdatavalid), 32'(0));
            chk("own_rdata", 32'(who == 0 ? m0_readdata : m1_readdata), 32'(base + 16'(i)));
        end
        step(); s_readdatavalid = 1'b0; settle();
        chk("rdata_done_idle", 32'(dbg_state), 32'(IDLE));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0, wr0;
        bit held_bad, burst_bad;
        reset = 1'b1;
        set_m(0, 1'b0, 1'b0, '0, '0, 9'd1);
        set_m(1, 1'b0, 1'b0, '0, '0, 9'd1);
        m0_byteenable = 2'b11; m1_byteenable = 2'b11;
        s_waitrequest = 1'b0; s_readdatavalid = 1'b0; s_readdata = '0;

        // Reset values
        repeat (3) step();
        settle();
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        chk("rst_m0_wait", 32'(m0_waitrequest), 32'(1));
        chk("rst_m1_wait", 32'(m1_waitrequest), 32'(1));
        chk("rst_s_read", 32'(s_read), 32'(0));
        chk("rst_s_write", 32'(s_write), 32'(0));
        chk("rst_m0_rdv", 32'(m0_readdatavalid), 32'(0));
        chk("rst_m0_rdata", 32'(m0_readdata), 32'(0));

        // m0 read bc=8 alone
        step(); reset = 1'b0;
        set_m(0, 1'b1, 1'b0, 22'h000100, '0, 9'd8);
        rd0 = rd_cmds;
        settle();
        chk("t1_req_wait", 32'(m0_waitrequest), 32'(1));
        check_grant(0, 1'b1, 22'h000100, 9'd8);
        read_beats(0, 8, 16'hA000, 1'b0);
        chk("t1_rd_cmds", 32'(rd_cmds - rd0), 32'(1));

        // Simultaneous reads after reset: m0, m1, m0, m1
        step(); reset = 1'b1;
        step(); reset = 1'b0;
        set_m(0, 1'b1, 1'b0, 22'h000010, '0, 9'd1);
        set_m(1, 1'b1, 1'b0, 22'h000020, '0, 9'd1);
        check_grant(0, 1'b1, 22'h000010, 9'd1);
        read_beats(0, 1, 16'h1100, 1'b0);
        check_grant(1, 1'b1, 22'h000020, 9'd1);
        m0_read = 1'b1;
        read_beats(1, 1, 16'h2200, 1'b1);
        check_grant(0, 1'b1, 22'h000010, 9'd1);
        read_beats(0, 1, 16'h3300, 1'b0);
        check_grant(1, 1'b1, 22'h000020, 9'd1);
        read_beats(1, 1, 16'h4400, 1'b0);

        // m1 write bc=4 with one stalled cycle on the first beat
        step();
        set_m(1, 1'b0, 1'b1, 22'h000200, 16'h000A, 9'd4);
        m1_byteenable = 2'b01;
        s_waitrequest = 1'b1;
        wr0 = wr_beats;
        settle();
        chk("t3_idle", 32'(dbg_state), 32'(IDLE));
        step(); settle();
        chk("t3_grant", 32'(dbg_state), 32'(GRANT));
        chk("t3_s_write", 32'(s_write), 32'(1));
        chk("t3_stall_wait", 32'(m1_waitrequest), 32'(1));
        chk("t3_wdata0", 32'(s_writedata), 32'h000A);
        chk("t3_be", 32'(s_byteenable), 32'(2'b01));
        step(); s_waitrequest = 1'b0; settle();
        chk("t3_grant_go", 32'(dbg_state), 32'(GRANT));
        chk("t3_wait_low", 32'(m1_waitrequest), 32'(0));
        for (int k = 1; k < 4; k++) begin
            step();
            m1_address = 22'h000200 + 22'(k); m1_writedata = 16'h000A + 16'(k);
            settle();
            chk("t3_wburst", 32'(dbg_state), 32'(WBURST));
            chk("t3_wdata", 32'(s_writedata), 32'(16'h000A + 16'(k)));
            chk("t3_waddr", 32'(s_address), 32'(22'h000200 + 22'(k)));
        end
        step(); settle();
        chk("t3_wdone", 32'(dbg_state), 32'(WDONE));
        chk("t3_wdone_s_write", 32'(s_write), 32'(0));
        chk("t3_wdone_wait", 32'(m1_waitrequest), 32'(1));
        step(); m1_write = 1'b0; m1_byteenable = 2'b11; settle();
        chk("t3_idle_after", 32'(dbg_state), 32'(IDLE));
        chk("t3_beats", 32'(wr_beats - wr0), 32'(4));

        // m0 write bc=256 while m1 read waits
        step();
        set_m(0, 1'b0, 1'b1, 22'h000300, 16'h0000, 9'd256);
        set_m(1, 1'b1, 1'b0, 22'h000040, '0, 9'd2);
        wr0 = wr_beats;
        settle();
        check_grant(0, 1'b0, 22'h000300, 9'd256);
        held_bad = 1'b0; burst_bad = 1'b0;
        for (int i = 0; i < 256; i++) begin
            if (i != 0) begin
                step(); m0_address = 22'h000300 + 22'(i); m0_writedata = 16'(i); settle();
            end
            if (i == 100) begin
                s_waitrequest = 1'b1; #1;
                chk("t4_stall_wait", 32'(m0_waitrequest), 32'(1));
                step(); s_waitrequest = 1'b0; settle();
            end
            if (m1_waitrequest !== 1'b1) held_bad = 1'b1;
            if (dbg_state !== ((i == 0) ? GRANT : WBURST)) burst_bad = 1'b1;
            if (s_writedata !== 16'(i) || s_write !== 1'b1) burst_bad = 1'b1;
        end
        chk("t4_m1_held", 32'(held_bad), 32'(0));
        chk("t4_burst", 32'(burst_bad), 32'(0));
        step(); m0_write = 1'b0; settle();
        chk("t4_wdone", 32'(dbg_state), 32'(WDONE));
        chk("t4_wdone_m1_wait", 32'(m1_waitrequest), 32'(1));
        step(); settle();
        chk("t4_idle", 32'(dbg_state), 32'(IDLE));
        chk("t4_beats", 32'(wr_beats - wr0), 32'(256));
        check_grant(1, 1'b1, 22'h000040, 9'd2);
        read_beats(1, 2, 16'h5500, 1'b0);

        // Reset during RDATA after 3 of 8 beats
        step();
        set_m(0, 1'b1, 1'b0, 22'h000500, '0, 9'd8);
        settle();
        check_grant(0, 1'b1, 22'h000500, 9'd8);
        step(); m0_read = 1'b0; settle();
        chk("t5_rdata", 32'(dbg_state), 32'(RDATA));
        for (int i = 0; i < 3; i++) begin
            step(); s_readdatavalid = 1'b1; s_readdata = 16'h6600 + 16'(i); settle();
            chk("t5_rdv", 32'(m0_readdatavalid), 32'(1));
        end
        step(); reset = 1'b1; s_readdata = 16'h6603;
        set_m(1, 1'b1, 1'b0, 22'h000060, '0, 9'd1);
        step(); settle();
        chk("t5_rst_state", 32'(dbg_state), 32'(IDLE));
        chk("t5_rst_m0_wait", 32'(m0_waitrequest), 32'(1));
        chk("t5_rst_m1_wait", 32'(m1_waitrequest), 32'(1));
        chk("t5_rst_m0_rdv", 32'(m0_readdatavalid), 32'(0));
        chk("t5_rst_m0_rdata", 32'(m0_readdata), 32'(0));
        chk("t5_rst_m1_rdv", 32'(m1_readdatavalid), 32'(0));
        chk("t5_rst_s_read", 32'(s_read), 32'(0));
        chk("t5_rst_s_write", 32'(s_write), 32'(0));
        // last_grant is back to 1, so m0 wins the tie even though it went last.
        step(); reset = 1'b0; s_readdatavalid = 1'b0;
        set_m(0, 1'b1, 1'b0, 22'h000050, '0, 9'd1);
        check_grant(0, 1'b1, 22'h000050, 9'd1);
        read_beats(0, 1, 16'h6700, 1'b0);
        check_grant(1, 1'b1, 22'h000060, 9'd1);
        read_beats(1, 1, 16'h6800, 1'b0);

        // Stray s_readdatavalid in IDLE
        step(); s_readdatavalid = 1'b1; s_readdata = 16'hBEEF; settle();
        chk("t6_state", 32'(dbg_state), 32'(IDLE));
        chk("t6_m0_rdv", 32'(m0_readdatavalid), 32'(0));
        chk("t6_m1_rdv", 32'(m1_readdatavalid), 32'(0));
        chk("t6_m0_rdata", 32'(m0_readdata), 32'(0));
        chk("t6_m1_rdata", 32'(m1_readdata), 32'(0));
        step(); s_readdatavalid = 1'b0;
        set_m(1, 1'b1, 1'b0, 22'h000070, '0, 9'd2);
        check_grant(1, 1'b1, 22'h000070, 9'd2);
        read_beats(1, 2, 16'h7700, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
